// File: rtl/shifter_iterativo.sv
// Iterative ARMv4 operand-2 shifter: LSL/LSR/ASR/ROR one bit per clock, RRX and
// pass-through in a single cycle, with ARM-exact carry-out for 8-bit shift amounts.
module shifter_iterativo #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [2:0]   mode,
  input  logic [7:0]   amount,
  input  logic [N-1:0] a,
  input  logic         carry_in,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] z,
  output logic         carry_out
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  typedef enum logic [2:0] {
    OP_LSL = 3'b000,
    OP_LSR = 3'b001,
    OP_ASR = 3'b010,
    OP_ROR = 3'b011,
    OP_RRX = 3'b100
  } op_t;

  localparam logic [7:0] LIN_MAX  = 8'(N + 1);
  localparam logic [7:0] ROT_MASK = 8'(N - 1);

  state_t     state;
  logic [2:0] mode_q;
  logic [7:0] count;
  logic [7:0] k;
  logic [7:0] ror_m1;
  logic       accept;

  assign accept = start && (state != S_SHIFT);

  // Linear shifts saturate at N+1 steps: one step past N flushes the carry to 0 (or sign for ASR).
  always_comb begin
    ror_m1 = amount - 8'd1;
    k      = '0;
    case (mode)
      OP_LSL, OP_LSR, OP_ASR: k = (amount > LIN_MAX) ? LIN_MAX : amount;
      OP_ROR:                 k = (amount == 8'd0) ? 8'd0 : (ror_m1 & ROT_MASK) + 8'd1;
      default:                k = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      mode_q    <= '0;
      count     <= '0;
      z         <= '0;
      carry_out <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (accept) begin
      mode_q <= mode;
      if (mode == OP_RRX) begin
        z         <= {carry_in, a[N-1:1]};
        carry_out <= a[0];
        count     <= '0;
        state     <= S_DONE;
        busy      <= 1'b0;
        done      <= 1'b1;
      end else begin
        z         <= a;
        carry_out <= carry_in;
        count     <= k;
        if (k == 8'd0) begin
          state <= S_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end else begin
          state <= S_SHIFT;
          busy  <= 1'b1;
          done  <= 1'b0;
        end
      end
    end else begin
      case (state)
        S_SHIFT: begin
          case (mode_q)
            OP_LSL: begin
              carry_out <= z[N-1];
              z         <= {z[N-2:0], 1'b0};
            end
            OP_LSR: begin
              carry_out <= z[0];
              z         <= {1'b0, z[N-1:1]};
            end
            OP_ASR: begin
              carry_out <= z[0];
              z         <= {z[N-1], z[N-1:1]};
            end
            OP_ROR: begin
              carry_out <= z[0];
              z         <= {z[0], z[N-1:1]};
            end
            default: begin
              carry_out <= carry_out;
              z         <= z;
            end
          endcase
          count <= count - 8'd1;
          if (count == 8'd1) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shifter_iterativo.sv
// Directed bench for shifter_iterativo (N=32): results, carry, latency, handshake and reset.
module tb_shifter_iterativo;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  mode = '0;
  logic [7:0]  amount = '0;
  logic [31:0] a = '0;
  logic        carry_in = 1'b0;
  logic        busy, done, carry_out;
  logic [31:0] z;

  int tests = 0;
  int fails = 0;
  logic overlap = 1'b0;

  shifter_iterativo #(.N(32)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .amount(amount),
    .a(a), .carry_in(carry_in), .busy(busy), .done(done), .z(z),
    .carry_out(carry_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Caller is positioned at a negedge; returns 1 ns after the accepting posedge.
  task automatic launch(input logic [2:0] m, input logic [7:0] amt,
                        input logic [31:0] av, input logic cin);
    mode = m; amount = amt; a = av; carry_in = cin; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int busyc);
    lat = -1;
    busyc = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (busy && done) overlap = 1'b1;
      if (done) begin
        lat = c;
        break;
      end
      if (busy) busyc++;
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] m, input logic [7:0] amt,
                        input logic [31:0] av, input logic cin,
                        input logic [31:0] ez, input logic ec, input int elat);
    int lat, bc;
    @(negedge clk);
    launch(m, amt, av, cin);
    wait_done(lat, bc);
    chk({tag, "_z"}, z, ez);
    chk({tag, "_c"}, 32'(carry_out), 32'(ec));
    chk({tag, "_lat"}, 32'(lat), 32'(elat));
  endtask

  initial begin
    int lat, bc;

    #1 rst = 1'b1;
    #1;
    chk("rst_z", z, 32'h0);
    chk("rst_c", 32'(carry_out), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // LSL #4 with busy count and result hold
    @(negedge clk);
    launch(3'b000, 8'd4, 32'h0000_00F1, 1'b0);
    wait_done(lat, bc);
    chk("lsl4_z", z, 32'h0000_0F10);
    chk("lsl4_c", 32'(carry_out), 32'h0);
    chk("lsl4_lat", 32'(lat), 32'd5);
    chk("lsl4_busy", 32'(bc), 32'd4);
    @(negedge clk);
    chk("lsl4_done_pulse", 32'(done), 32'h0);
    chk("lsl4_hold", z, 32'h0000_0F10);

    run_op("lsr32",  3'b001, 8'd32,  32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 33);
    run_op("lsr33",  3'b001, 8'd33,  32'h8000_0000, 1'b1, 32'h0000_0000, 1'b0, 34);
    run_op("asr200", 3'b010, 8'd200, 32'h8000_0000, 1'b0, 32'hFFFF_FFFF, 1'b1, 34);
    run_op("asr4",   3'b010, 8'd4,   32'hF000_0000, 1'b1, 32'hFF00_0000, 1'b0, 5);
    run_op("ror33",  3'b011, 8'd33,  32'h8000_0001, 1'b0, 32'hC000_0000, 1'b1, 2);
    run_op("ror32",  3'b011, 8'd32,  32'h8000_0002, 1'b0, 32'h8000_0002, 1'b1, 33);
    run_op("rrx",    3'b100, 8'd9,   32'h0000_0003, 1'b1, 32'h8000_0001, 1'b1, 1);
    run_op("lsl0",   3'b000, 8'd0,   32'h1234_5678, 1'b1, 32'h1234_5678, 1'b1, 1);
    run_op("lsl32",  3'b000, 8'd32,  32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 33);
    run_op("lsl40",  3'b000, 8'd40,  32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1'b0, 34);
    run_op("pass",   3'b101, 8'd7,   32'hA5A5_5A5A, 1'b1, 32'hA5A5_5A5A, 1'b1, 1);

    // start during SHIFT must be ignored
    @(negedge clk);
    launch(3'b000, 8'd8, 32'h0000_0001, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    launch(3'b001, 8'd1, 32'hFFFF_FFFF, 1'b1);
    wait_done(lat, bc);
    chk("ign_z", z, 32'h0000_0100);
    chk("ign_c", 32'(carry_out), 32'h0);
    chk("ign_lat", 32'(3 + lat), 32'd9);

    // back-to-back: new start accepted in the DONE cycle
    @(negedge clk);
    launch(3'b011, 8'd33, 32'h8000_0001, 1'b0);
    wait_done(lat, bc);
    chk("b2b1_z", z, 32'hC000_0000);
    chk("b2b1_lat", 32'(lat), 32'd2);
    launch(3'b001, 8'd5, 32'h0000_00F0, 1'b0);
    wait_done(lat, bc);
    chk("b2b2_z", z, 32'h0000_0007);
    chk("b2b2_c", 32'(carry_out), 32'h1);
    chk("b2b2_lat", 32'(lat), 32'd6);

    // asynchronous reset mid-SHIFT
    @(negedge clk);
    launch(3'b011, 8'd20, 32'hDEAD_BEEF, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_z", z, 32'h0);
    chk("mid_rst_c", 32'(carry_out), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    begin
      logic seen_done = 1'b0;
      for (int c = 0; c < 25; c++) begin
        @(negedge clk);
        if (done || busy) seen_done = 1'b1;
      end
      chk("mid_rst_no_done", 32'(seen_done), 32'h0);
    end
    run_op("post_rst", 3'b000, 8'd1, 32'h8000_0001, 1'b0, 32'h0000_0002, 1'b1, 2);

    chk("busy_done_excl", 32'(overlap), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
